// File: rtl/pc_ch_mux_pkg.sv
// Shared types and helpers for the PC channel router: frame state encoding,
// drop counter ceiling and a popcount used to tally discarded RX bytes.
package pc_ch_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  function automatic logic [4:0] popcount16(input logic [15:0] vec);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'b0000, vec[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/pc_ch_mux_if.sv
// Link-side and PC-side byte streams of the channel router. The master
// modport is the router itself; the slave modport is its surroundings.
interface pc_ch_mux_if #(
  parameter int CH_NUM = 4,
  parameter int DW     = 8
);

  logic [CH_NUM*DW-1:0] ch_rx_data;
  logic [CH_NUM-1:0]    ch_rx_valid;
  logic [CH_NUM*DW-1:0] ch_tx_data;
  logic [CH_NUM-1:0]    ch_tx_en;
  logic [DW-1:0]        pc_tx_data;
  logic                 pc_tx_valid;
  logic [DW-1:0]        pc_rx_data;
  logic                 pc_rx_valid;

  modport master (
    input  ch_rx_data, ch_rx_valid, pc_tx_data, pc_tx_valid,
    output ch_tx_data, ch_tx_en, pc_rx_data, pc_rx_valid
  );

  modport slave (
    output ch_rx_data, ch_rx_valid, pc_tx_data, pc_tx_valid,
    input  ch_tx_data, ch_tx_en, pc_rx_data, pc_rx_valid
  );

endinterface

// File: rtl/pc_ch_mux_gap_timer.sv
// Idle-gap timer: counts cycles without activity and pulses gap_done on the
// cycle that completes a GAP_CYC-long silence, which ends the current frame.
module pc_gap_timer #(
  parameter int GAP_CYC = 1000,
  parameter int GAP_W   = 16
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic act,
  input  logic clr,
  output logic gap_done
);

  logic [GAP_W-1:0] cnt;

  assign gap_done = !act && (cnt == GAP_W'(GAP_CYC - 1));

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (act || clr || gap_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pc_ch_mux.sv
// N-channel PC data router: muxes the active link's RX bytes to the PC and
// steers PC TX bytes to that link, changing links only between frames.
module pc_ch_mux
  import pc_ch_pkg::*;
#(
  parameter int U_DLY   = 1,
  parameter int CH_NUM  = 4,
  parameter int DW      = 8,
  parameter int CH_W    = 2,
  parameter int GAP_CYC = 1000,
  parameter int GAP_W   = 16
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  pc_ch_mux_if.master      bus,
  input  logic [CH_W-1:0]  ch_sel,
  input  logic             sel_force,
  output logic [CH_W-1:0]  ch_act,
  output logic             frame_busy,
  output logic             sw_pending,
  output logic             sel_err,
  output logic [15:0]      drop_cnt
);

  state_t              state, state_nxt;
  logic [CH_W-1:0]     ch_act_nxt;
  logic [CH_NUM-1:0]   act_onehot;
  logic [DW-1:0]       rx_data_sel;
  logic [CH_NUM*DW-1:0] tx_data_nxt;
  logic [CH_NUM-1:0]   tx_en_nxt;
  logic                act, sel_ok, sel_change, force_sw, tmr_clr, gap_done;
  logic [16:0]         drop_sum;

  // Active channel as a one-hot mask; drives both the RX mux and TX demux.
  always_comb begin
    act_onehot  = '0;
    rx_data_sel = '0;
    tx_en_nxt   = '0;
    tx_data_nxt = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      act_onehot[k] = (ch_act == CH_W'(k));
      if (act_onehot[k]) begin
        rx_data_sel            = bus.ch_rx_data[k*DW +: DW];
        tx_en_nxt[k]           = bus.pc_tx_valid;
        tx_data_nxt[k*DW +: DW] = bus.pc_tx_data;
      end
    end
  end

  assign act        = |(bus.ch_rx_valid & act_onehot) | bus.pc_tx_valid;
  assign sel_ok     = int'(ch_sel) < CH_NUM;
  assign sel_change = sel_ok && (ch_sel != ch_act);
  assign force_sw   = sel_change && sel_force;
  assign tmr_clr    = (state == ST_IDLE) || force_sw;

  assign frame_busy = (state == ST_BUSY);
  assign sw_pending = sel_change;
  assign sel_err    = !sel_ok;

  pc_gap_timer #(
    .GAP_CYC (GAP_CYC),
    .GAP_W   (GAP_W)
  ) u_gap_timer (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .act      (act),
    .clr      (tmr_clr),
    .gap_done (gap_done)
  );

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      ch_act <= '0;
    end else begin
      state  <= state_nxt;
      ch_act <= ch_act_nxt;
    end
  end

  // A forced switch wins outright; otherwise a switch needs an idle, silent cycle.
  always_comb begin
    state_nxt  = state;
    ch_act_nxt = ch_act;
    if (force_sw) begin
      ch_act_nxt = ch_sel;
      state_nxt  = ST_IDLE;
    end else if (state == ST_IDLE) begin
      if (act) begin
        state_nxt = ST_BUSY;
      end else if (sel_change) begin
        ch_act_nxt = ch_sel;
      end
    end else if (gap_done) begin
      state_nxt = ST_IDLE;
    end
  end

  assign drop_sum = {1'b0, drop_cnt}
                  + 17'(popcount16(16'(bus.ch_rx_valid & ~act_onehot)));

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      bus.pc_rx_data  <= '0;
      bus.pc_rx_valid <= 1'b0;
      bus.ch_tx_data  <= '0;
      bus.ch_tx_en    <= '0;
      drop_cnt        <= '0;
    end else begin
      bus.pc_rx_data  <= rx_data_sel;
      bus.pc_rx_valid <= |(bus.ch_rx_valid & act_onehot);
      bus.ch_tx_data  <= tx_data_nxt;
      bus.ch_tx_en    <= tx_en_nxt;
      drop_cnt        <= drop_sum[16] ? DROP_MAX : drop_sum[15:0];
    end
  end

endmodule

// File: tb/tb_pc_ch_mux.sv
// Directed bench for pc_ch_mux: a 4-channel instance with an 8-cycle gap and
// a 3-channel instance for out-of-range selects and drop counting.
module tb_pc_ch_mux;

  logic        clk_sys;
  logic        rst_n;
  logic [1:0]  ch_sel_a, ch_act_a, ch_sel_b, ch_act_b;
  logic        sel_force_a, frame_busy_a, sw_pending_a, sel_err_a;
  logic        sel_force_b, frame_busy_b, sw_pending_b, sel_err_b;
  logic [15:0] drop_cnt_a, drop_cnt_b;
  int          checks;
  int          errors;

  pc_ch_mux_if #(.CH_NUM(4), .DW(8)) bus_a ();
  pc_ch_mux_if #(.CH_NUM(3), .DW(8)) bus_b ();

  pc_ch_mux #(
    .U_DLY(1), .CH_NUM(4), .DW(8), .CH_W(2), .GAP_CYC(8), .GAP_W(4)
  ) dut_a (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .bus        (bus_a),
    .ch_sel     (ch_sel_a),
    .sel_force  (sel_force_a),
    .ch_act     (ch_act_a),
    .frame_busy (frame_busy_a),
    .sw_pending (sw_pending_a),
    .sel_err    (sel_err_a),
    .drop_cnt   (drop_cnt_a)
  );

  pc_ch_mux #(
    .U_DLY(1), .CH_NUM(3), .DW(8), .CH_W(2), .GAP_CYC(8), .GAP_W(4)
  ) dut_b (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .bus        (bus_b),
    .ch_sel     (ch_sel_b),
    .sel_force  (sel_force_b),
    .ch_act     (ch_act_b),
    .frame_busy (frame_busy_b),
    .sw_pending (sw_pending_b),
    .sel_err    (sel_err_b),
    .drop_cnt   (drop_cnt_b)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Drives instance A for one cycle, then returns 1 time unit after the edge.
  task automatic applyStimulus(input logic [3:0] rx_valid, input logic [31:0] rx_data,
                               input logic tx_valid, input logic [7:0] tx_data,
                               input logic [1:0] sel, input logic frc);
    bus_a.ch_rx_valid = rx_valid;
    bus_a.ch_rx_data  = rx_data;
    bus_a.pc_tx_valid = tx_valid;
    bus_a.pc_tx_data  = tx_data;
    ch_sel_a          = sel;
    sel_force_a       = frc;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 'h%0h expected 'h%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus_a.ch_rx_valid = '0; bus_a.ch_rx_data = '0;
    bus_a.pc_tx_valid = 1'b0; bus_a.pc_tx_data = '0;
    bus_b.ch_rx_valid = '0; bus_b.ch_rx_data = '0;
    bus_b.pc_tx_valid = 1'b0; bus_b.pc_tx_data = '0;
    ch_sel_a = '0; sel_force_a = 1'b0;
    ch_sel_b = '0; sel_force_b = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    checkOutput("reset_ch_act", 32'(ch_act_a), 32'h0);
    checkOutput("reset_rx_valid", 32'(bus_a.pc_rx_valid), 32'h0);
    checkOutput("reset_busy", 32'(frame_busy_a), 32'h0);
    checkOutput("reset_tx_en", 32'(bus_a.ch_tx_en), 32'h0);
    checkOutput("reset_drop", 32'(drop_cnt_a), 32'h0);
    rst_n = 1'b1;

    $display("[TB] basic RX forwarding on channel 0");
    applyStimulus(4'b0001, 32'h0000_00A5, 1'b0, 8'h00, 2'd0, 1'b0);
    checkOutput("rx_valid", 32'(bus_a.pc_rx_valid), 32'h1);
    checkOutput("rx_data", 32'(bus_a.pc_rx_data), 32'hA5);
    checkOutput("rx_ch_act", 32'(ch_act_a), 32'h0);
    checkOutput("rx_busy", 32'(frame_busy_a), 32'h1);
    applyStimulus(4'b0000, 32'h0000_005A, 1'b0, 8'h00, 2'd0, 1'b0);
    checkOutput("rx_idle_valid", 32'(bus_a.pc_rx_valid), 32'h0);
    checkOutput("rx_idle_data", 32'(bus_a.pc_rx_data), 32'h5A);

    $display("[TB] deferred switch to channel 2 during a frame");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0001, 32'(i), 1'b0, 8'h00, 2'd2, 1'b0);
      applyStimulus(4'b0000, 32'(i), 1'b0, 8'h00, 2'd2, 1'b0);
      applyStimulus(4'b0000, 32'(i), 1'b0, 8'h00, 2'd2, 1'b0);
      checkOutput("frame_hold_act", 32'(ch_act_a), 32'h0);
      checkOutput("frame_pending", 32'(sw_pending_a), 32'h1);
    end
    applyStimulus(4'b0001, 32'h11, 1'b0, 8'h00, 2'd2, 1'b0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(4'b0000, 32'h11, 1'b0, 8'h00, 2'd2, 1'b0);
    end
    checkOutput("gap7_busy", 32'(frame_busy_a), 32'h1);
    checkOutput("gap7_act", 32'(ch_act_a), 32'h0);
    applyStimulus(4'b0000, 32'h11, 1'b0, 8'h00, 2'd2, 1'b0);
    checkOutput("gap8_busy", 32'(frame_busy_a), 32'h0);
    checkOutput("gap8_act", 32'(ch_act_a), 32'h0);
    applyStimulus(4'b0000, 32'h11, 1'b0, 8'h00, 2'd2, 1'b0);
    checkOutput("gap9_act", 32'(ch_act_a), 32'h2);
    checkOutput("gap9_pending", 32'(sw_pending_a), 32'h0);

    $display("[TB] TX demux to channel 1");
    applyStimulus(4'b0000, 32'h0, 1'b0, 8'h00, 2'd1, 1'b0);
    checkOutput("sw1_act", 32'(ch_act_a), 32'h1);
    applyStimulus(4'b0000, 32'h0, 1'b1, 8'h3C, 2'd1, 1'b0);
    checkOutput("tx_en", 32'(bus_a.ch_tx_en), 32'h2);
    checkOutput("tx_data", bus_a.ch_tx_data, 32'h0000_3C00);
    checkOutput("tx_busy", 32'(frame_busy_a), 32'h1);

    $display("[TB] forced switch to channel 3 mid-frame");
    applyStimulus(4'b0000, 32'h0, 1'b0, 8'h00, 2'd3, 1'b1);
    checkOutput("force_act", 32'(ch_act_a), 32'h3);
    checkOutput("force_busy", 32'(frame_busy_a), 32'h0);
    checkOutput("force_tx_en", 32'(bus_a.ch_tx_en), 32'h0);
    checkOutput("force_tx_data", bus_a.ch_tx_data, 32'h0);
    applyStimulus(4'b1000, 32'hC300_0000, 1'b0, 8'h00, 2'd3, 1'b0);
    checkOutput("force_rx_valid", 32'(bus_a.pc_rx_valid), 32'h1);
    checkOutput("force_rx_data", 32'(bus_a.pc_rx_data), 32'hC3);
    checkOutput("force_rx_busy", 32'(frame_busy_a), 32'h1);
    checkOutput("force_no_drop", 32'(drop_cnt_a), 32'h0);

    $display("[TB] out-of-range select and drop count on 3-channel instance");
    ch_sel_b = 2'd3;
    #1;
    checkOutput("b_sel_err", 32'(sel_err_b), 32'h1);
    checkOutput("b_no_pending", 32'(sw_pending_b), 32'h0);
    sel_force_b = 1'b1;
    applyStimulus(4'b0000, 32'h0, 1'b0, 8'h00, 2'd3, 1'b0);
    checkOutput("b_hold_act", 32'(ch_act_b), 32'h0);
    checkOutput("b_sel_err_force", 32'(sel_err_b), 32'h1);
    ch_sel_b = 2'd0;
    sel_force_b = 1'b0;
    bus_b.ch_rx_valid = 3'b110;
    bus_b.ch_rx_data  = 24'h77_66_00;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'b0000, 32'h0, 1'b0, 8'h00, 2'd3, 1'b0);
    end
    bus_b.ch_rx_valid = '0;
    checkOutput("b_drop20", 32'(drop_cnt_b), 32'd20);
    checkOutput("b_sel_err_clear", 32'(sel_err_b), 32'h0);
    checkOutput("b_rx_valid", 32'(bus_b.pc_rx_valid), 32'h0);

    $display("[TB] asynchronous reset mid-frame");
    applyStimulus(4'b1000, 32'hC400_0000, 1'b0, 8'h00, 2'd3, 1'b0);
    checkOutput("pre_rst_valid", 32'(bus_a.pc_rx_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_rx_valid", 32'(bus_a.pc_rx_valid), 32'h0);
    checkOutput("rst_rx_data", 32'(bus_a.pc_rx_data), 32'h0);
    checkOutput("rst_ch_act", 32'(ch_act_a), 32'h0);
    checkOutput("rst_busy", 32'(frame_busy_a), 32'h0);
    checkOutput("rst_drop_b", 32'(drop_cnt_b), 32'h0);
    applyStimulus(4'b0000, 32'h0, 1'b0, 8'h00, 2'd0, 1'b0);
    rst_n = 1'b1;

    $display("[TB] drop counter saturation");
    applyStimulus(4'b1110, 32'h0, 1'b0, 8'h00, 2'd0, 1'b0);
    checkOutput("drop3", 32'(drop_cnt_a), 32'd3);
    checkOutput("drop_rx_valid", 32'(bus_a.pc_rx_valid), 32'h0);
    for (int i = 0; i < 21843; i++) begin
      applyStimulus(4'b1110, 32'h0, 1'b0, 8'h00, 2'd0, 1'b0);
    end
    applyStimulus(4'b0110, 32'h0, 1'b0, 8'h00, 2'd0, 1'b0);
    checkOutput("drop_fffe", 32'(drop_cnt_a), 32'hFFFE);
    applyStimulus(4'b0110, 32'h0, 1'b0, 8'h00, 2'd0, 1'b0);
    checkOutput("drop_sat", 32'(drop_cnt_a), 32'hFFFF);
    applyStimulus(4'b1110, 32'h0, 1'b0, 8'h00, 2'd0, 1'b0);
    checkOutput("drop_sat_hold", 32'(drop_cnt_a), 32'hFFFF);
    applyStimulus(4'b0000, 32'h0, 1'b0, 8'h00, 2'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
